// File: rtl/mem_lower_pkg.sv
// Shared types and helpers for the lowered masked 1R1W memories:
// FSM state encoding, derived-width helpers and the per-lane merge.
package mem_lower_pkg;

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    // Widest word the generic merge helper handles; callers cast in and out.
    localparam int MERGE_MAX_W = 1024;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int mask_w(input int width, input int gran);
        return width / gran;
    endfunction

    // Lane i of the result comes from new_word when mask[i] is set, else from old_word.
    function automatic logic [MERGE_MAX_W-1:0] merge(
        input logic [MERGE_MAX_W-1:0] old_word,
        input logic [MERGE_MAX_W-1:0] new_word,
        input logic [MERGE_MAX_W-1:0] mask,
        input int                     gran
    );
        logic [MERGE_MAX_W-1:0] res;
        for (int i = 0; i < MERGE_MAX_W; i++) begin
            res[i] = mask[i / gran] ? new_word[i] : old_word[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_1r1w_masked_core.sv
// Raw masked 1R1W array: one-cycle registered read, undefined output on a same-cycle
// collision. Maps to xpm_memory_sdpram (BYTE_WRITE_WIDTH_A = MASK_GRAN) on Xilinx.
module mem_1r1w_masked_core
    import mem_lower_pkg::*;
#(
    parameter  int DEPTH     = 32,
    parameter  int WIDTH     = 136,
    parameter  int MASK_GRAN = 8,
    localparam int ADDR_W    = addr_w(DEPTH),
    localparam int MASK_W    = mask_w(WIDTH, MASK_GRAN)
) (
    input  logic              clock,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [WIDTH-1:0]  w_data,
    input  logic [MASK_W-1:0] w_mask,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [WIDTH-1:0]  r_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the array and its read register carry no reset so they map onto a RAM macro;
    // defined contents come from the wrapper's zero-fill instead.
    always_ff @(posedge clock) begin
        if (w_en) begin
            for (int l = 0; l < MASK_W; l++) begin
                if (w_mask[l]) begin
                    mem[w_addr][l*MASK_GRAN +: MASK_GRAN] <= w_data[l*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
        if (r_en) begin
            r_data <= mem[r_addr];
        end
    end

endmodule

// File: rtl/mem_1r1w_masked_fwd.sv
// Masked 1R1W memory wrapper: post-reset zero-fill, write-first collision forwarding,
// out-of-range handling, read-valid strobe and an optional output register.
module mem_1r1w_masked_fwd
    import mem_lower_pkg::*;
#(
    parameter  int DEPTH        = 32,
    parameter  int WIDTH        = 136,
    parameter  int MASK_GRAN    = 8,
    parameter  int READ_LATENCY = 1,
    parameter  int INIT_ZERO    = 1,
    localparam int ADDR_W       = addr_w(DEPTH),
    localparam int MASK_W       = mask_w(WIDTH, MASK_GRAN)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] R0_addr,
    input  logic              R0_en,
    output logic [WIDTH-1:0]  R0_data,
    output logic              R0_valid,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic              W0_en,
    input  logic [WIDTH-1:0]  W0_data,
    input  logic [MASK_W-1:0] W0_mask,
    output logic              init_busy
);

    state_t            state;
    logic [ADDR_W-1:0] cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
            cnt       <= '0;
            init_busy <= (INIT_ZERO != 0);
        end else begin
            case (state)
                ST_INIT: begin
                    cnt <= cnt + ADDR_W'(1);
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state     <= ST_RUN;
                        init_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    logic run, w_ok, r_issue, r_in_range;
    assign run        = (state == ST_RUN);
    assign w_ok       = run && W0_en && (int'(W0_addr) < DEPTH);
    assign r_issue    = run && R0_en;
    assign r_in_range = (int'(R0_addr) < DEPTH);

    logic [WIDTH-1:0] core_q;

    mem_1r1w_masked_core #(
        .DEPTH    (DEPTH),
        .WIDTH    (WIDTH),
        .MASK_GRAN(MASK_GRAN)
    ) u_core (
        .clock (clock),
        .w_en  (!run || w_ok),
        .w_addr(run ? W0_addr : cnt),
        .w_data(run ? W0_data : '0),
        .w_mask(run ? W0_mask : '1),
        .r_en  (r_issue && r_in_range),
        .r_addr(R0_addr),
        .r_data(core_q)
    );

    // Issue-stage state; only refreshed on a read so the result holds between reads.
    logic              rd_v1, seen1, hit1, oob1;
    logic [WIDTH-1:0]  fwd_data;
    logic [MASK_W-1:0] fwd_mask;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_v1    <= 1'b0;
            seen1    <= 1'b0;
            hit1     <= 1'b0;
            oob1     <= 1'b0;
            fwd_data <= '0;
            fwd_mask <= '0;
        end else begin
            rd_v1 <= r_issue;
            if (r_issue) begin
                seen1    <= 1'b1;
                oob1     <= !r_in_range;
                hit1     <= w_ok && (R0_addr == W0_addr);
                fwd_data <= W0_data;
                fwd_mask <= W0_mask;
            end
        end
    end

    logic [WIDTH-1:0] data1;

    // NOTE: every path through this block starts from a default so no latch is inferred.
    always_comb begin
        data1 = '0;
        if (seen1 && !oob1) begin
            if (hit1) begin
                data1 = WIDTH'(merge(MERGE_MAX_W'(core_q), MERGE_MAX_W'(fwd_data),
                                     MERGE_MAX_W'(fwd_mask), MASK_GRAN));
            end else begin
                data1 = core_q;
            end
        end
    end

    if (READ_LATENCY == 2) begin : g_out_reg
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                R0_valid <= 1'b0;
                R0_data  <= '0;
            end else begin
                R0_valid <= rd_v1;
                if (rd_v1) begin
                    R0_data <= data1;
                end
            end
        end
    end else begin : g_out_comb
        assign R0_valid = rd_v1;
        assign R0_data  = data1;
    end

endmodule

// File: tb/tb_mem_1r1w_masked_fwd.sv
// Directed bench: latency-1 and latency-2 instances share stimulus; expected values are
// hand-derived constants and a small write pattern.
module tb_mem_1r1w_masked_fwd;

    logic         clock;
    logic         reset_n;
    logic [4:0]   R0_addr;
    logic         R0_en;
    logic [4:0]   W0_addr;
    logic         W0_en;
    logic [135:0] W0_data;
    logic [16:0]  W0_mask;

    logic [135:0] r_data1, r_data2;
    logic         r_valid1, r_valid2, busy1, busy2;

    int checks   = 0;
    int failures = 0;

    localparam logic [135:0] ONES = '1;

    mem_1r1w_masked_fwd #(.READ_LATENCY(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(r_data1), .R0_valid(r_valid1),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask),
        .init_busy(busy1)
    );

    mem_1r1w_masked_fwd #(.READ_LATENCY(2)) u_dut2 (
        .clock(clock), .reset_n(reset_n),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(r_data2), .R0_valid(r_valid2),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask),
        .init_busy(busy2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [135:0] got, input logic [135:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [135:0] pat(input int a);
        logic [7:0] b;
        b = 8'(a) ^ 8'h5A;
        return {17{b}};
    endfunction

    // Counts fill cycles while junk requests are driven; none may produce a read strobe.
    task automatic wait_fill(input string tag);
        int   n;
        logic any_valid;
        n         = 0;
        any_valid = 1'b0;
        R0_en   = 1'b1; R0_addr = 5'd5;
        W0_en   = 1'b1; W0_addr = 5'd5; W0_data = ONES; W0_mask = '1;
        while (busy1 && n < 100) begin
            step();
            n++;
            any_valid = any_valid | r_valid1 | r_valid2;
        end
        R0_en = 1'b0;
        W0_en = 1'b0;
        check({tag, "_busy_cycles"}, 136'(n), 136'd32);
        check({tag, "_busy2_low"}, 136'(busy2), 136'd0);
        check({tag, "_no_valid_in_init"}, 136'(any_valid), 136'd0);
    endtask

    initial begin
        reset_n = 1'b0;
        R0_en = 1'b0; R0_addr = '0;
        W0_en = 1'b0; W0_addr = '0; W0_data = '0; W0_mask = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_data1", r_data1, 136'd0);
        check("rst_data2", r_data2, 136'd0);
        check("rst_valid1", 136'(r_valid1), 136'd0);
        check("rst_valid2", 136'(r_valid2), 136'd0);
        check("rst_busy", 136'(busy1), 136'd1);
        reset_n = 1'b1;

        wait_fill("fill0");

        // Streaming reads of the zero-filled array, including the address hit in INIT.
        for (int a = 0; a <= 32; a++) begin
            R0_en   = (a < 32);
            R0_addr = 5'(a);
            step();
            if (a < 32) begin
                check("zero_v1", 136'(r_valid1), 136'd1);
                check("zero_d1", r_data1, 136'd0);
            end
            if (a >= 1) begin
                check("zero_v2", 136'(r_valid2), 136'd1);
                check("zero_d2", r_data2, 136'd0);
            end
        end

        // Distinct pattern per word, then an in-order stream of 32 results.
        for (int a = 0; a < 32; a++) begin
            W0_en = 1'b1; W0_addr = 5'(a); W0_data = pat(a); W0_mask = '1;
            step();
        end
        W0_en = 1'b0;
        for (int a = 0; a <= 32; a++) begin
            R0_en   = (a < 32);
            R0_addr = 5'(a);
            step();
            if (a < 32) begin
                check("strm_v1", 136'(r_valid1), 136'd1);
                check("strm_d1", r_data1, pat(a));
            end else begin
                check("strm_end_v1", 136'(r_valid1), 136'd0);
            end
            if (a >= 1) begin
                check("strm_v2", 136'(r_valid2), 136'd1);
                check("strm_d2", r_data2, pat(a - 1));
            end
        end
        step();
        check("hold_d1", r_data1, pat(31));
        check("hold_v1", 136'(r_valid1), 136'd0);
        check("hold_d2", r_data2, pat(31));
        check("hold_v2", 136'(r_valid2), 136'd0);

        // Partial-mask overwrite: only lane 0 of addr 5 cleared.
        W0_en = 1'b1; W0_addr = 5'd5; W0_data = ONES; W0_mask = '1;
        step();
        W0_data = '0; W0_mask = 17'h00001;
        step();
        W0_en = 1'b0; R0_en = 1'b1; R0_addr = 5'd5;
        step();
        R0_en = 1'b0;
        check("mask_v1", 136'(r_valid1), 136'd1);
        check("mask_d1", r_data1, ~136'hFF);
        step();
        check("mask_v2", 136'(r_valid2), 136'd1);
        check("mask_d2", r_data2, ~136'hFF);

        // All-zero mask write is a no-op.
        W0_en = 1'b1; W0_addr = 5'd5; W0_data = '0; W0_mask = '0;
        step();
        W0_en = 1'b0; R0_en = 1'b1;
        step();
        R0_en = 1'b0;
        check("nomask_d1", r_data1, ~136'hFF);

        // Same-cycle read/write to addr 9: top lane forwarded, rest from old word.
        W0_en = 1'b1; W0_addr = 5'd9; W0_data = '0; W0_mask = '1;
        step();
        R0_en = 1'b1; R0_addr = 5'd9; W0_data = ONES; W0_mask = 17'h10000;
        step();
        R0_en = 1'b0; W0_en = 1'b0;
        check("fwd_v1", 136'(r_valid1), 136'd1);
        check("fwd_d1", r_data1, {8'hFF, 128'h0});
        step();
        check("fwd_v2", 136'(r_valid2), 136'd1);
        check("fwd_d2", r_data2, {8'hFF, 128'h0});
        check("fwd_v1_off", 136'(r_valid1), 136'd0);

        // Write issued the cycle after a read stays invisible to that read.
        R0_en = 1'b1; R0_addr = 5'd3;
        step();
        check("late_d1", r_data1, pat(3));
        R0_en = 1'b0; W0_en = 1'b1; W0_addr = 5'd3; W0_data = ONES; W0_mask = '1;
        step();
        W0_en = 1'b0;
        check("late_v2", 136'(r_valid2), 136'd1);
        check("late_d2", r_data2, pat(3));
        R0_en = 1'b1;
        step();
        R0_en = 1'b0;
        check("after_d1", r_data1, ONES);
        step();
        check("after_d2", r_data2, ONES);

        // Reset mid-stream drops in-flight reads at once.
        R0_en = 1'b1; R0_addr = 5'd1;
        step();
        R0_addr = 5'd2;
        step();
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_v1", 136'(r_valid1), 136'd0);
        check("mid_rst_v2", 136'(r_valid2), 136'd0);
        check("mid_rst_d2", r_data2, 136'd0);
        check("mid_rst_busy", 136'(busy1), 136'd1);
        R0_en = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        wait_fill("fill1");

        // Reset during the fill restarts it from word 0.
        #2;
        reset_n = 1'b0;
        #1;
        check("init_rst_busy", 136'(busy1), 136'd1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        R0_en = 1'b1; W0_en = 1'b1; W0_addr = 5'd7; W0_data = ONES; W0_mask = '1;
        repeat (10) step();
        check("init_mid_busy", 136'(busy1), 136'd1);
        check("init_mid_v1", 136'(r_valid1), 136'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("init_rst2_v1", 136'(r_valid1), 136'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        wait_fill("fill2");

        // Contents are zero again and INIT-time writes left nothing behind.
        for (int k = 0; k < 4; k++) begin
            R0_en = 1'b1;
            R0_addr = (k == 0) ? 5'd3 : (k == 1) ? 5'd5 : (k == 2) ? 5'd7 : 5'd9;
            step();
            check("refill_v1", 136'(r_valid1), 136'd1);
            check("refill_d1", r_data1, 136'd0);
        end
        R0_en = 1'b0;
        step();
        check("refill_d2", r_data2, 136'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
